// File: rtl/mul_fitness_pkg.sv
// Shared types and the bit-sliced golden 2x2 product used by the fitness scorer.
// golden_slice is sized to FIT_LANES; the scorer's LANES parameter must match it.
package mul_fitness_pkg;

   localparam int PROD_BITS = 4;
   localparam int FIT_LANES = 16;

   typedef enum logic [1:0] {ACCUM, DRAIN, DONE} fit_state_e;

   // Bit-sliced 2x2 multiply: row k holds product bit k for every lane.
   function automatic logic [PROD_BITS-1:0][FIT_LANES-1:0] golden_slice(
      input logic [FIT_LANES-1:0] a1,
      input logic [FIT_LANES-1:0] a0,
      input logic [FIT_LANES-1:0] b1,
      input logic [FIT_LANES-1:0] b0
   );
      logic [PROD_BITS-1:0][FIT_LANES-1:0] p;
      logic [FIT_LANES-1:0]                all4;
      all4 = a0 & a1 & b0 & b1;
      p[0] = a0 & b0;
      p[1] = (a1 & b0) ^ (a0 & b1);
      p[2] = (a1 & b1) ^ all4;
      p[3] = all4;
      return p;
   endfunction

endpackage

// File: rtl/fit_popcount.sv
// Combinational population count of a W-bit vector.
module fit_popcount #(
   parameter  int W  = 4,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  vec,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/mul2x2_fitness_scorer.sv
// Scores an evolved 2x2 multiplier candidate against the golden product over
// NUM_BEATS bit-sliced beats and hands one fitness result downstream.
module mul2x2_fitness_scorer
   import mul_fitness_pkg::*;
#(
   parameter  int LANES     = FIT_LANES,
   parameter  int NUM_BEATS = 4,
   localparam int SCORE_W   = $clog2(4 * LANES * NUM_BEATS + 1),
   localparam int LANE_W    = $clog2(LANES * NUM_BEATS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES-1:0]   a1,
   input  logic [LANES-1:0]   a0,
   input  logic [LANES-1:0]   b1,
   input  logic [LANES-1:0]   b0,
   input  logic [LANES-1:0]   y3,
   input  logic [LANES-1:0]   y2,
   input  logic [LANES-1:0]   y1,
   input  logic [LANES-1:0]   y0,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SCORE_W-1:0] score,
   output logic [LANE_W-1:0]  lane_score,
   output logic               perfect
);

   localparam int CNT_W   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int BIT_W   = PROD_BITS * LANES;
   localparam int BIT_CW  = $clog2(BIT_W + 1);
   localparam int LANE_CW = $clog2(LANES + 1);
   localparam int FULL    = PROD_BITS * LANES * NUM_BEATS;

   fit_state_e                          state;
   logic [CNT_W-1:0]                    beat_cnt;
   logic                                accept;
   logic                                last_beat;
   logic [PROD_BITS-1:0][LANES-1:0]     gold;
   logic [PROD_BITS-1:0][LANES-1:0]     y_bus;
   logic [PROD_BITS-1:0][LANES-1:0]     match_p1;
   logic                                vld_p1;
   logic                                last_p1;
   logic [LANES-1:0]                    lane_ok_p1;
   logic [BIT_CW-1:0]                   bit_hits;
   logic [LANE_CW-1:0]                  lane_hits;
   logic [SCORE_W-1:0]                  score_nxt;
   logic [LANE_W-1:0]                   lane_nxt;

   // Beats are refused during clear/rst and whenever an evaluation is draining or parked.
   assign in_ready  = !rst && !clear && (state == ACCUM);
   assign accept    = in_valid && in_ready;
   assign last_beat = (beat_cnt == CNT_W'(NUM_BEATS - 1));
   assign gold      = golden_slice(a1, a0, b1, b0);
   assign y_bus     = {y3, y2, y1, y0};

   // ---- stage 0 -> stage 1: per-bit match mask ----
   always_ff @(posedge clk) begin
      if (accept) begin
         match_p1 <= ~(y_bus ^ gold);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else begin
         vld_p1  <= accept;
         last_p1 <= accept && last_beat;
      end
   end

   // ---- stage 1 -> stage 2: hit counting and accumulation ----
   assign lane_ok_p1 = match_p1[3] & match_p1[2] & match_p1[1] & match_p1[0];

   fit_popcount #(.W(BIT_W)) u_bit_pop (
      .vec   (match_p1),
      .count (bit_hits)
   );

   fit_popcount #(.W(LANES)) u_lane_pop (
      .vec   (lane_ok_p1),
      .count (lane_hits)
   );

   assign score_nxt = score + SCORE_W'(bit_hits);
   assign lane_nxt  = lane_score + LANE_W'(lane_hits);

   // The accumulators double as the registered result outputs.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state      <= ACCUM;
         beat_cnt   <= '0;
         score      <= '0;
         lane_score <= '0;
         perfect    <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         if (vld_p1) begin
            score      <= score_nxt;
            lane_score <= lane_nxt;
            perfect    <= (score_nxt == SCORE_W'(FULL));
         end
         case (state)
            ACCUM: begin
               if (accept) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     state    <= DRAIN;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (vld_p1 && last_p1) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state      <= ACCUM;
                  out_valid  <= 1'b0;
                  score      <= '0;
                  lane_score <= '0;
                  perfect    <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
